// File: rtl/fb_pkg.sv
// Frame store geometry and state encodings shared by the framebuffer and the
// board/box drawing FSMs that feed it.
package fb_pkg;
  localparam int FB_WIDTH    = 160;
  localparam int FB_HEIGHT   = 120;
  localparam int FB_COLOUR_W = 3;
  localparam int FB_PIXELS   = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W   = $clog2(FB_PIXELS);
  localparam logic [FB_COLOUR_W-1:0] FB_CLEAR_COLOUR = '0;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_SCAN  = 2'd2
  } fb_state_t;

  // Position tag carried alongside each pixel through the read pipeline.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       last;
  } fb_meta_t;
endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// A same-address write and read in one cycle returns the old data.
module fb_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/pixel_framebuffer.sv
// Pixel frame store: accepts drawer writes, clears on reset/request and
// replays the frame as a row-major valid/ready raster stream.
module pixel_framebuffer
  import fb_pkg::*;
#(
  parameter int WIDTH    = FB_WIDTH,
  parameter int HEIGHT   = FB_HEIGHT,
  parameter int COLOUR_W = FB_COLOUR_W,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = FB_CLEAR_COLOUR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                writeEn,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear_req,
  input  logic                scan_start,
  output logic                busy,
  output logic                scan_valid,
  input  logic                scan_ready,
  output logic [7:0]          scan_x,
  output logic [6:0]          scan_y,
  output logic [COLOUR_W-1:0] scan_colour,
  output logic                scan_last,
  output logic                frame_done
);
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [7:0] X_LIM = 8'(WIDTH);
  localparam logic [7:0] X_END = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LIM = 7'(HEIGHT);

  fb_state_t state, state_nx;
  logic [ADDR_W-1:0] ctr, pix_addr, waddr;
  logic [7:0] rx;
  logic [6:0] ry;
  logic issued_all, scan_pend, clear_pend;
  logic rd_pend, out_vld, skid_vld, frame_done_r;
  fb_meta_t rd_meta, out_meta, skid_meta;
  logic [COLOUR_W-1:0] ram_q, out_col, skid_col, wdata;
  logic [1:0] occ;
  logic pop, last_pop, room, start_scan, rd_en, clr_we, px_we, we;

  assign pop        = out_vld && scan_ready;
  assign last_pop   = pop && out_meta.last;
  assign start_scan = (state == S_IDLE) && !(clear_req || clear_pend) && (scan_start || scan_pend);

  // A read may issue only if, after this cycle's pop, the output register plus
  // skid can absorb everything in flight including the new read.
  assign occ  = 2'(rd_pend) + 2'(out_vld) + 2'(skid_vld);
  assign room = (occ - {1'b0, pop}) < 2'd2;
  assign rd_en = start_scan || ((state == S_SCAN) && !issued_all && room);

  assign pix_addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  assign clr_we   = (state == S_CLEAR);
  assign px_we    = writeEn && !clr_we && (x < X_LIM) && (y < Y_LIM);
  assign we       = clr_we || px_we;
  assign waddr    = clr_we ? ctr : pix_addr;
  assign wdata    = clr_we ? CLEAR_COLOUR : colour;

  fb_ram #(.DEPTH(PIXELS), .ADDR_W(ADDR_W), .DATA_W(COLOUR_W)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (ctr),
    .q     (ram_q)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: if (ctr == LAST_ADDR) state_nx = S_IDLE;
      S_IDLE: begin
        if (clear_req || clear_pend) state_nx = S_CLEAR;
        else if (start_scan)         state_nx = S_SCAN;
      end
      S_SCAN:  if (last_pop) state_nx = S_IDLE;
      default: state_nx = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_CLEAR;
      ctr          <= '0;
      rx           <= '0;
      ry           <= '0;
      issued_all   <= 1'b0;
      scan_pend    <= 1'b0;
      clear_pend   <= 1'b0;
      rd_pend      <= 1'b0;
      out_vld      <= 1'b0;
      skid_vld     <= 1'b0;
      out_meta     <= '0;
      out_col      <= '0;
      frame_done_r <= 1'b0;
    end else begin
      state        <= state_nx;
      frame_done_r <= last_pop;

      if (start_scan)      scan_pend <= 1'b0;
      else if (scan_start) scan_pend <= 1'b1;

      if (state == S_IDLE)                      clear_pend <= 1'b0;
      else if (clear_req && (state == S_SCAN))  clear_pend <= 1'b1;

      // ctr is the clear write address in CLEAR and the read pointer in SCAN
      if (state == S_CLEAR) begin
        ctr <= (ctr == LAST_ADDR) ? '0 : ctr + 1'b1;
      end else if (last_pop) begin
        ctr        <= '0;
        rx         <= '0;
        ry         <= '0;
        issued_all <= 1'b0;
      end else if (rd_en) begin
        if (ctr == LAST_ADDR) issued_all <= 1'b1;
        else                  ctr <= ctr + 1'b1;
        if (rx == X_END) begin
          rx <= '0;
          ry <= ry + 1'b1;
        end else begin
          rx <= rx + 1'b1;
        end
      end

      rd_pend      <= rd_en;
      rd_meta.x    <= rx;
      rd_meta.y    <= ry;
      rd_meta.last <= (ctr == LAST_ADDR);

      // Skid always holds the older pixel, so it drains into the output first.
      if (!out_vld || pop) begin
        if (skid_vld) begin
          out_meta  <= skid_meta;
          out_col   <= skid_col;
          out_vld   <= 1'b1;
          skid_vld  <= rd_pend;
          skid_meta <= rd_meta;
          skid_col  <= ram_q;
        end else if (rd_pend) begin
          out_meta <= rd_meta;
          out_col  <= ram_q;
          out_vld  <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_meta <= rd_meta;
        skid_col  <= ram_q;
        skid_vld  <= 1'b1;
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign scan_valid  = out_vld;
  assign scan_x      = out_meta.x;
  assign scan_y      = out_meta.y;
  assign scan_last   = out_meta.last;
  assign scan_colour = out_col;
  assign frame_done  = frame_done_r;
endmodule

// File: tb/tb_pixel_framebuffer.sv
// Scoreboard bench for pixel_framebuffer: a frame-array model snapshots the
// expected raster at each scan request; a negedge monitor checks handshakes.
module tb_pixel_framebuffer;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       last;
  } pix_t;

  logic clock = 1'b0;
  logic reset, writeEn, clear_req, scan_start, scan_ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic busy, scan_valid, scan_last, frame_done;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;

  pixel_framebuffer dut (
    .clock(clock), .reset(reset), .writeEn(writeEn), .x(x), .y(y), .colour(colour),
    .clear_req(clear_req), .scan_start(scan_start), .busy(busy),
    .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_x(scan_x), .scan_y(scan_y),
    .scan_colour(scan_colour), .scan_last(scan_last), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  logic [2:0] model [N];
  pix_t expq[$];
  int hs_cnt = 0, sevens = 0;
  logic [2:0] seen10 = 3'd7, seen53 = 3'd0;
  logic [17:0] seen_last = '0;
  bit mon_en = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) model[i] = 3'd0;
  endtask

  // Expected raster for one full pass, taken from the frame as it stands now.
  task automatic push_frame();
    pix_t p;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        p.x = 8'(xx); p.y = 7'(yy); p.c = model[yy*W + xx];
        p.last = (xx == W-1) && (yy == H-1);
        expq.push_back(p);
      end
  endtask

  task automatic do_write(input int xx, input int yy, input int cc);
    writeEn = 1'b1; x = 8'(xx); y = 7'(yy); colour = 3'(cc);
    if (xx < W && yy < H) model[yy*W + xx] = 3'(cc);
    @(posedge clock); #1;
    writeEn = 1'b0;
  endtask

  // Counts busy cycles; optionally throws writes at the store meanwhile.
  task automatic wait_clear(input bit poke, output int n);
    n = 0;
    while (busy === 1'b1 && n < 30000) begin
      n++;
      if (poke) begin
        writeEn = 1'b1; x = 8'($urandom_range(0, 255));
        y = 7'($urandom_range(0, 127)); colour = 3'($urandom_range(1, 7));
      end
      @(posedge clock); #1;
    end
    writeEn = 1'b0;
  endtask

  // Monitor: scoreboard pop, stall stability and frame_done timing.
  pix_t prev_out;
  bit stall_prev = 0, exp_fd = 0, fd_next;
  always @(negedge clock) begin
    if (mon_en) begin
      pix_t e, cur;
      cur = '{x: scan_x, y: scan_y, c: scan_colour, last: scan_last};
      check("frame_done_timing", 32'(frame_done), 32'(exp_fd));
      fd_next = 0;
      if (stall_prev && !reset) begin
        check("stall_valid_held", 32'(scan_valid), 32'd1);
        check("stall_data_held", 32'(cur), 32'(prev_out));
      end
      if (scan_valid && scan_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_pixel", 32'(cur), 32'h7ffff);
        end else begin
          e = expq.pop_front();
          check("pixel", 32'(cur), 32'(e));
          fd_next = e.last;
        end
        hs_cnt++;
        if (scan_colour == 3'd7) sevens++;
        if (scan_x == 8'd10 && scan_y == 7'd0) seen10 = scan_colour;
        if (scan_x == 8'd5 && scan_y == 7'd3) seen53 = scan_colour;
        if (scan_last) seen_last = {scan_x, scan_y, scan_colour};
      end
      stall_prev = scan_valid && !scan_ready;
      prev_out = cur;
      exp_fd = fd_next;
    end
  end

  initial begin
    int n, cyc, base;
    bit fd;
    reset = 1'b1; writeEn = 1'b0; clear_req = 1'b0; scan_start = 1'b0; scan_ready = 1'b1;
    x = '0; y = '0; colour = '0;
    model_clear();
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_valid", 32'(scan_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_scan_xyc", {13'd0, scan_x, scan_y, scan_colour, scan_last}, 32'd0);
    mon_en = 1;

    // Reset clear: writes thrown in this window must vanish.
    wait_clear(1'b1, n);
    check("clear_len_reset", 32'(n), 32'd19200);
    check("idle_after_clear", 32'(busy), 32'd0);

    do_write(5, 3, 5);
    do_write(159, 119, 2);
    do_write(160, 0, 7);
    do_write(0, 120, 7);
    for (int i = 0; i < 40; i++) begin
      int xx, yy;
      xx = $urandom_range(20, 200); yy = $urandom_range(4, 127);
      if (!(xx == 159 && yy == 119)) do_write(xx, yy, $urandom_range(0, 6));
    end

    // Scan A: latency, read-first collision at (10,0), then a stalled stretch.
    base = hs_cnt;
    push_frame();
    scan_start = 1'b1;
    @(posedge clock); #1;
    scan_start = 1'b0;
    check("first_valid_c1", 32'(scan_valid), 32'd0);
    @(posedge clock); #1;
    check("first_valid_c2", 32'(scan_valid), 32'd1);
    repeat (8) begin @(posedge clock); #1; end
    writeEn = 1'b1; x = 8'd10; y = 7'd0; colour = 3'd6; model[10] = 3'd6;
    @(posedge clock); #1;
    writeEn = 1'b0;
    cyc = 11; fd = 0;
    while (!fd && cyc < 50000) begin
      scan_ready = (cyc < 200) ? 1'b1 : (cyc < 3200) ? ($urandom_range(0, 99) < 30) : 1'b1;
      @(posedge clock); #1;
      cyc++;
      if (frame_done) fd = 1;
    end
    scan_ready = 1'b1;
    check("scan_a_frame_done", 32'(fd), 32'd1);
    check("scan_a_handshakes", 32'(hs_cnt - base), 32'd19200);
    check("scan_a_idle", 32'(busy), 32'd0);
    check("scan_a_no_colour7", 32'(sevens), 32'd0);
    check("pixel_5_3", 32'(seen53), 32'd5);
    check("last_pixel", 32'(seen_last), {14'd0, 8'd159, 7'd119, 3'd2});
    check("read_first_old", 32'(seen10), 32'd0);

    // Scan B: collision write now visible; reset lands at pixel 5000.
    base = hs_cnt;
    push_frame();
    scan_start = 1'b1;
    @(posedge clock); #1;
    scan_start = 1'b0;
    cyc = 0;
    while ((hs_cnt - base) < 5000 && cyc < 10000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("scan_b_reach_5000", 32'(hs_cnt - base), 32'd5000);
    check("next_pass_new_value", 32'(seen10), 32'd6);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    expq.delete();
    model_clear();
    check("midrst_valid", 32'(scan_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_outputs", {13'd0, scan_x, scan_y, scan_colour, scan_last}, 32'd0);
    wait_clear(1'b0, n);
    check("clear_len_midreset", 32'(n), 32'd19200);

    // Clear and scan requested together: clear first, then scan on its own.
    base = hs_cnt;
    clear_req = 1'b1; scan_start = 1'b1;
    push_frame();
    @(posedge clock); #1;
    clear_req = 1'b0; scan_start = 1'b0;
    wait_clear(1'b0, n);
    check("clear_len_request", 32'(n), 32'd19200);
    cyc = 0;
    while (!scan_valid && cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("auto_scan_valid", 32'(scan_valid), 32'd1);
    cyc = 0;
    while ((hs_cnt - base) < 300 && cyc < 1000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("auto_scan_pixels", 32'(hs_cnt - base), 32'd300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
